// File: rtl/execute_unit_pkg.sv
// Shared opcode and execute-state definitions for the execute stage.
// Optional feature macro: EXEC_MUL_EN (opcode C becomes MUL).
package execute_unit_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_NREGS  = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_INC  = 4'hA,
    OP_DEC  = 4'hB,
    OP_MUL  = 4'hC,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    EX_IDLE,
    EX_READ,
    EX_EXEC,
    EX_DONE,
    EX_HALT
  } ex_state_e;

  function automatic logic op_illegal(input logic [3:0] op);
`ifdef EXEC_MUL_EN
    return (op == 4'hD) || (op == 4'hE);
`else
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
`endif
  endfunction

endpackage

// File: rtl/execute_unit_alu.sv
// Combinational ALU: (op, a, b) -> result, flags and writeback enable.
// MUL on opcode C exists only when EXEC_MUL_EN is defined.
module alu
  import execute_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z_out,
  output logic              wr_en
);

  logic [DATA_W:0] wide;
`ifdef EXEC_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  always_comb begin
    wide   = '0;
    result = '0;
    c_out  = c_in;
    wr_en  = 1'b1;
`ifdef EXEC_MUL_EN
    prod   = '0;
`endif
    case (op)
      OP_MOV: result = a;
      OP_ADD: begin
        wide   = {1'b0, b} + {1'b0, a};
        result = wide[DATA_W-1:0];
        c_out  = wide[DATA_W];
      end
      OP_SUB: begin
        // the 9th bit of a wrapped subtraction is the borrow
        wide   = {1'b0, b} - {1'b0, a};
        result = wide[DATA_W-1:0];
        c_out  = wide[DATA_W];
      end
      OP_AND: begin result = b & a; c_out = 1'b0; end
      OP_OR:  begin result = b | a; c_out = 1'b0; end
      OP_XOR: begin result = b ^ a; c_out = 1'b0; end
      OP_NOT: begin result = ~a;    c_out = 1'b0; end
      OP_SHL: begin
        result = {b[DATA_W-2:0], 1'b0};
        c_out  = b[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, b[DATA_W-1:1]};
        c_out  = b[0];
      end
      OP_INC: begin
        wide   = {1'b0, b} + (DATA_W+1)'(1);
        result = wide[DATA_W-1:0];
        c_out  = wide[DATA_W];
      end
      OP_DEC: begin
        wide   = {1'b0, b} - (DATA_W+1)'(1);
        result = wide[DATA_W-1:0];
        c_out  = wide[DATA_W];
      end
`ifdef EXEC_MUL_EN
      OP_MUL: begin
        prod   = b * a;
        result = prod[DATA_W-1:0];
        c_out  = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: wr_en = 1'b0;
    endcase
  end

  assign z_out = (result == '0);

endmodule

// File: rtl/execute_unit.sv
// Execute stage: FSM, 4-entry register file and Z/C flags around the alu.
// Define EXEC_MUL_EN to enable MUL on opcode C.
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic [3:0]               opcode,
  input  logic [$clog2(NREGS)-1:0] src,
  input  logic [$clog2(NREGS)-1:0] dst,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal,
  output logic                     halted,
  output logic                     flag_z,
  output logic                     flag_c,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned SEL_W = $clog2(NREGS);

  ex_state_e state, state_next;

  logic [3:0]        op_q;
  logic [SEL_W-1:0]  src_q, dst_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] alu_result;
  logic              alu_c, alu_z, alu_wr;

  alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .c_in   (flag_c),
    .result (alu_result),
    .c_out  (alu_c),
    .z_out  (alu_z),
    .wr_en  (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EX_IDLE;
      op_q   <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        EX_IDLE: if (ready) begin
          op_q  <= opcode;
          src_q <= src;
          dst_q <= dst;
        end
        EX_READ: begin
          a_q <= regs[src_q];
          b_q <= regs[dst_q];
        end
        EX_EXEC: if (alu_wr) begin
          regs[dst_q] <= alu_result;
          flag_z      <= alu_z;
          flag_c      <= alu_c;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state)
      EX_IDLE: if (ready) state_next = EX_READ;
      EX_READ: begin
        busy       = 1'b1;
        state_next = EX_EXEC;
      end
      EX_EXEC: begin
        busy       = 1'b1;
        state_next = (op_q == OP_HALT) ? EX_HALT : EX_DONE;
      end
      EX_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        illegal    = op_illegal(op_q);
        state_next = EX_IDLE;
      end
      EX_HALT: halted = 1'b1;
      default: state_next = EX_IDLE;
    endcase
  end

  assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit with hand-computed expectations.
// Honours EXEC_MUL_EN for the opcode C case.
module tb_execute_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] opcode = '0;
  logic [1:0] src = '0;
  logic [1:0] dst = '0;
  logic [1:0] dbg_sel = '0;
  logic       busy, done, illegal, halted, flag_z, flag_c;
  logic [7:0] dbg_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  execute_unit #(.DATA_W(8), .NREGS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .opcode   (opcode),
    .src      (src),
    .dst      (dst),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .halted   (halted),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c);
    check({tag, "_z"}, flag_z, z);
    check({tag, "_c"}, flag_c, c);
  endtask

  // Issues one instruction, measures cycles from ready to done and checks illegal.
  task automatic exec_op(input string tag, input logic [3:0] op, input logic [1:0] s,
                         input logic [1:0] d, input logic exp_ill);
    int n;
    @(negedge clk);
    ready = 1'b1; opcode = op; src = s; dst = d;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    n = 1;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_ill"}, illegal, exp_ill);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] done_seen;
    logic       any_done;

    // 1: reset then idle
    do_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ill", illegal, 0);
    check("rst_halted", halted, 0);
    check_flags("rst", 0, 0);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);

    // 2: R1=FF, R2=01 then ADD src2 dst1
    exec_op("not", 4'h7, 2'd0, 2'd1, 0);
    check_reg("not_r1", 2'd1, 8'hFF);
    exec_op("inc", 4'hA, 2'd0, 2'd2, 0);
    check_reg("inc_r2", 2'd2, 8'h01);
    exec_op("add", 4'h2, 2'd2, 2'd1, 0);
    check_reg("add_r1", 2'd1, 8'h00);
    check_flags("add", 1, 1);

    // 3: SUB 03-05, MOV keeps C, SHR 01
    for (int i = 0; i < 3; i++) exec_op("inc0", 4'hA, 2'd0, 2'd0, 0);
    for (int i = 0; i < 5; i++) exec_op("inc1", 4'hA, 2'd0, 2'd1, 0);
    check_reg("pre_r0", 2'd0, 8'h03);
    check_reg("pre_r1", 2'd1, 8'h05);
    exec_op("sub", 4'h3, 2'd1, 2'd0, 0);
    check_reg("sub_r0", 2'd0, 8'hFE);
    check_flags("sub", 0, 1);
    exec_op("mov", 4'h1, 2'd2, 2'd0, 0);
    check_reg("mov_r0", 2'd0, 8'h01);
    check_flags("mov", 0, 1);
    exec_op("shr", 4'h9, 2'd3, 2'd0, 0);
    check_reg("shr_r0", 2'd0, 8'h00);
    check_flags("shr", 1, 1);

    // 4: ready held high; fields changed mid-instruction take effect next IDLE only
    @(negedge clk);
    ready = 1'b1; opcode = 4'hA; src = 2'd0; dst = 2'd3;
    done_seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) opcode = 4'hB;
      done_seen[i] = done;
      if (i == 2) check_reg("held_r3_a", 2'd3, 8'h01);
      if (i == 6) begin
        check_reg("held_r3_b", 2'd3, 8'h00);
        ready = 1'b0;
      end
    end
    check("held_done_pattern", done_seen, 8'b0100_0100);
    check_flags("dec", 1, 0);

    exec_op("opD", 4'hD, 2'd0, 2'd3, 1);
    check_reg("opD_r0", 2'd0, 8'h00);
    check_reg("opD_r1", 2'd1, 8'h05);
    check_reg("opD_r2", 2'd2, 8'h01);
    check_reg("opD_r3", 2'd3, 8'h00);
    check_flags("opD", 1, 0);

    // 6: opcode C with 0x10 * 0x10
    for (int i = 0; i < 4; i++) exec_op("shl", 4'h8, 2'd0, 2'd2, 0);
    check_reg("shl_r2", 2'd2, 8'h10);
    exec_op("mov3", 4'h1, 2'd2, 2'd3, 0);
    check_flags("mov3", 0, 0);
`ifdef EXEC_MUL_EN
    exec_op("mul", 4'hC, 2'd2, 2'd3, 0);
    check_reg("mul_r3", 2'd3, 8'h00);
    check_flags("mul", 1, 1);
`else
    exec_op("opC", 4'hC, 2'd2, 2'd3, 1);
    check_reg("opC_r3", 2'd3, 8'h10);
    check_flags("opC", 0, 0);
`endif

    // 5: HALT, later ready ignored
    @(negedge clk);
    ready = 1'b1; opcode = 4'hF; src = 2'd0; dst = 2'd0;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any_done |= done;
    end
    check("halt_done", any_done, 0);
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    ready = 1'b1; opcode = 4'hA; dst = 2'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_done |= done;
    end
    ready = 1'b0;
    check("halt_ign_done", any_done, 0);
    check("halt_ign_halted", halted, 1);
    check_reg("halt_ign_r1", 2'd1, 8'h05);

    do_reset();
    check("rst2_halted", halted, 0);
    for (int i = 0; i < 4; i++) check_reg("rst2_reg", 2'(i), 8'h00);

    // 5b: reset during EXEC of ADD aborts writeback
    for (int i = 0; i < 5; i++) exec_op("inc1b", 4'hA, 2'd0, 2'd1, 0);
    @(negedge clk);
    ready = 1'b1; opcode = 4'h2; src = 2'd1; dst = 2'd0;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("abort_busy_exec", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_halted", halted, 0);
    check_flags("abort", 0, 0);
    check_reg("abort_r0", 2'd0, 8'h00);
    @(negedge clk);
    check("abort_done_late", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
